// File: rtl/hgcal_pkg.sv
// Shared constants, types and packer state encoding for the hgcal_autoencoder
// input stage.
package hgcal_pkg;

    localparam int IN_WIDTH = 16;
    localparam int N_INPUTS = 48;
    localparam int QBITS    = 2;
    localparam int SHIFT    = 4;
    localparam int CNT_W    = 8;

    typedef logic [QBITS-1:0]          code_t;
    typedef logic [N_INPUTS*QBITS-1:0] frame_t;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/hgcal_quantizer.sv
// Combinational shift-and-saturate quantizer: unsigned sample -> QBITS-wide code,
// step size 2^SHIFT, no rounding.
module hgcal_quantizer
    import hgcal_pkg::*;
#(
    parameter int IN_WIDTH = hgcal_pkg::IN_WIDTH,
    parameter int QBITS    = hgcal_pkg::QBITS,
    parameter int SHIFT    = hgcal_pkg::SHIFT
) (
    input  logic [IN_WIDTH-1:0] din,
    output logic [QBITS-1:0]    code
);

    localparam logic [IN_WIDTH-1:0] CODE_MAX = IN_WIDTH'((1 << QBITS) - 1);

    logic [IN_WIDTH-1:0] q;

    always_comb begin
        q = din >> SHIFT;
        if (q > CODE_MAX) begin
            code = '1;
        end else begin
            code = q[QBITS-1:0];
        end
    end

endmodule

// File: rtl/hgcal_input_packer.sv
// Quantizes a sample stream and packs N_INPUTS codes per frame into one flat
// vector for the layer-0 LUTs; malformed frames are dropped and counted.
module hgcal_input_packer
    import hgcal_pkg::*;
#(
    parameter int IN_WIDTH = hgcal_pkg::IN_WIDTH,
    parameter int N_INPUTS = hgcal_pkg::N_INPUTS,
    parameter int QBITS    = hgcal_pkg::QBITS,
    parameter int SHIFT    = hgcal_pkg::SHIFT,
    parameter int CNT_W    = hgcal_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_WIDTH-1:0]       s_data,
    input  logic                      s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [N_INPUTS*QBITS-1:0] m_data,
    output logic                      err_len,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int FW    = N_INPUTS * QBITS;
    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [FW-1:0]    fill_buf;
    logic [FW-1:0]    fill_merged;
    logic [QBITS-1:0] code;

    logic accept;
    logic consume;
    logic out_free;
    logic wr_slot;
    logic idx_inc;
    logic idx_clr;
    logic load_merged;
    logic load_fill;
    logic drop;

    hgcal_quantizer #(
        .IN_WIDTH (IN_WIDTH),
        .QBITS    (QBITS),
        .SHIFT    (SHIFT)
    ) u_quant (
        .din  (s_data),
        .code (code)
    );

    assign s_ready  = (state != ST_HOLD);
    assign accept   = s_valid && s_ready;
    assign consume  = m_valid && m_ready;
    assign out_free = !m_valid || m_ready;

    // Fill buffer with the incoming code already in place, so a completing
    // frame can go straight to m_data in the same cycle.
    always_comb begin
        fill_merged = fill_buf;
        fill_merged[idx*QBITS +: QBITS] = code;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wr_slot     = 1'b0;
        idx_inc     = 1'b0;
        idx_clr     = 1'b0;
        load_merged = 1'b0;
        load_fill   = 1'b0;
        drop        = 1'b0;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (idx == LAST_IDX) begin
                        idx_clr = 1'b1;
                        if (s_last) begin
                            if (out_free) begin
                                load_merged = 1'b1;
                            end else begin
                                wr_slot  = 1'b1;
                                state_nx = ST_HOLD;
                            end
                        end else begin
                            drop     = 1'b1;
                            state_nx = ST_DISCARD;
                        end
                    end else if (s_last) begin
                        drop    = 1'b1;
                        idx_clr = 1'b1;
                    end else begin
                        wr_slot = 1'b1;
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    load_fill = 1'b1;
                    state_nx  = ST_FILL;
                end
            end
            ST_DISCARD: begin
                if (accept && s_last) begin
                    state_nx = ST_FILL;
                end
            end
            default: begin
                state_nx = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            fill_buf <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            err_len  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr_slot) begin
                fill_buf <= fill_merged;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (load_merged) begin
                m_data  <= fill_merged;
                m_valid <= 1'b1;
            end else if (load_fill) begin
                m_data  <= fill_buf;
                m_valid <= 1'b1;
            end else if (consume) begin
                m_valid <= 1'b0;
            end
            err_len <= drop;
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hgcal_input_packer.sv
// Self-checking bench for hgcal_input_packer with a 4-input frame and a 2-bit
// drop counter: fixed vectors, corner sequences, then random traffic.
module tb_hgcal_input_packer;

    localparam int NI = 4;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        err_len;
    logic [1:0]  drop_cnt;

    int n_pass;
    int n_total;
    int exp_drops;

    hgcal_input_packer #(
        .IN_WIDTH (16),
        .N_INPUTS (NI),
        .QBITS    (2),
        .SHIFT    (4),
        .CNT_W    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err_len  (err_len),
        .drop_cnt (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] s;
        logic [7:0]       exp;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat_drops();
        return (exp_drops > 3) ? 3 : exp_drops;
    endfunction

    function automatic logic [1:0] qref(input int unsigned x);
        int unsigned q;
        q = x / 16;
        return (q > 3) ? 2'd3 : 2'(q);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [15:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int i);
        for (int k = 0; k < NI; k++) begin
            put(tbl[i].s[k], k == NI - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        @(negedge clk);
        rst = 1'b1;
        exp_drops = 0;
    endtask

    // random-phase model state
    logic [7:0] q_frames[$];
    logic [7:0] cur_frame;
    int         cur_len;
    bit         discarding;
    int         drv_cnt;
    int         drv_target;
    int         targets[7] = '{4, 4, 4, 2, 5, 6, 1};

    task automatic model_cycle(input bit check_err);
        bit acc;
        bit hs;
        bit err_exp;
        chk("rnd_s_ready", s_ready, (q_frames.size() < 2) ? 1 : 0);
        chk("rnd_m_valid", m_valid, (q_frames.size() > 0) ? 1 : 0);
        if (q_frames.size() > 0) chk("rnd_m_data", m_data, q_frames[0]);
        acc = s_valid && (q_frames.size() < 2);
        hs  = m_ready && (q_frames.size() > 0);
        err_exp = 1'b0;
        if (hs) void'(q_frames.pop_front());
        if (acc) begin
            if (discarding) begin
                if (s_last) discarding = 1'b0;
            end else begin
                cur_frame = cur_frame | (8'(qref(s_data)) << (2 * cur_len));
                cur_len++;
                if (cur_len == NI) begin
                    if (s_last) begin
                        q_frames.push_back(cur_frame);
                    end else begin
                        exp_drops++;
                        err_exp = 1'b1;
                        discarding = 1'b1;
                    end
                    cur_len = 0;
                    cur_frame = '0;
                end else if (s_last) begin
                    exp_drops++;
                    err_exp = 1'b1;
                    cur_len = 0;
                    cur_frame = '0;
                end
            end
            drv_cnt++;
            if (s_last) begin
                drv_cnt = 0;
                drv_target = targets[$urandom_range(0, 6)];
            end
        end
        step();
        if (check_err) begin
            chk("rnd_err_len", err_len, err_exp);
            chk("rnd_drop_cnt", drop_cnt, sat_drops());
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        exp_drops = 0;
        rst = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        m_ready = 1'b0;

        tbl[0] = '{s: '{16'h0040, 16'h0025, 16'h0015, 16'h0005}, exp: 8'b11_10_01_00};
        tbl[1] = '{s: '{16'h0010, 16'hFFFF, 16'h003F, 16'h0000}, exp: 8'b01_11_11_00};
        tbl[2] = '{s: '{16'h0000, 16'h0010, 16'h0020, 16'h0030}, exp: 8'b00_01_10_11};
        tbl[3] = '{s: '{16'h0011, 16'h0035, 16'h1234, 16'h0040}, exp: 8'b01_11_11_11};
        tbl[4] = '{s: '{16'h002F, 16'h001F, 16'h000F, 16'h8000}, exp: 8'b10_01_00_11};

        #3;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_len", err_len, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        do_reset();

        // table: each frame must appear one cycle after its last accept
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_frame(i);
            chk("tbl_m_valid", m_valid, 1);
            chk("tbl_m_data", m_data, tbl[i].exp);
        end
        step();
        chk("tbl_idle_m_valid", m_valid, 0);

        // backpressure: second frame waits in HOLD
        m_ready = 1'b0;
        send_frame(0);
        chk("bp_a_valid", m_valid, 1);
        chk("bp_a_data", m_data, tbl[0].exp);
        for (int k = 0; k < NI; k++) begin
            chk("bp_s_ready_fill", s_ready, 1);
            put(tbl[1].s[k], k == NI - 1);
        end
        chk("bp_hold_s_ready", s_ready, 0);
        chk("bp_hold_data", m_data, tbl[0].exp);
        step();
        chk("bp_hold2_s_ready", s_ready, 0);
        chk("bp_hold2_data", m_data, tbl[0].exp);
        m_ready = 1'b1;
        step();
        chk("bp_b_valid", m_valid, 1);
        chk("bp_b_data", m_data, tbl[1].exp);
        chk("bp_b_s_ready", s_ready, 1);
        step();
        chk("bp_drained", m_valid, 0);

        // short frame
        put(16'h0030, 1'b0);
        put(16'h0030, 1'b0);
        put(16'h0030, 1'b1);
        exp_drops++;
        chk("short_err", err_len, 1);
        chk("short_cnt", drop_cnt, sat_drops());
        chk("short_m_valid", m_valid, 0);
        step();
        chk("short_err_pulse", err_len, 0);
        send_frame(3);
        chk("short_next_data", m_data, tbl[3].exp);
        chk("short_next_valid", m_valid, 1);

        // long frame: drop at the 4th accept, rest ignored
        for (int k = 0; k < 3; k++) put(16'h0020, 1'b0);
        put(16'h0020, 1'b0);
        exp_drops++;
        chk("long_err", err_len, 1);
        chk("long_cnt", drop_cnt, sat_drops());
        put(16'h0030, 1'b0);
        chk("long_err_once", err_len, 0);
        put(16'h0030, 1'b1);
        chk("long_err_end", err_len, 0);
        chk("long_m_valid", m_valid, 0);
        send_frame(4);
        chk("long_next_data", m_data, tbl[4].exp);
        chk("long_cnt_hold", drop_cnt, sat_drops());

        // drop counter saturation
        for (int i = 0; i < 5; i++) begin
            put(16'h0040, 1'b1);
            exp_drops++;
            chk("sat_err", err_len, 1);
            chk("sat_cnt", drop_cnt, sat_drops());
        end
        step();
        chk("sat_err_clear", err_len, 0);
        send_frame(0);
        chk("sat_next_data", m_data, tbl[0].exp);

        // reset mid-frame with a frame pending on the output
        m_ready = 1'b0;
        step();
        send_frame(1);
        put(16'h0030, 1'b0);
        put(16'h0030, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_s_ready", s_ready, 1);
        chk("mrst_m_valid", m_valid, 0);
        chk("mrst_m_data", m_data, 0);
        chk("mrst_err_len", err_len, 0);
        chk("mrst_drop_cnt", drop_cnt, 0);
        step();
        @(negedge clk);
        rst = 1'b1;
        exp_drops = 0;
        m_ready = 1'b1;
        send_frame(2);
        chk("mrst_next_valid", m_valid, 1);
        chk("mrst_next_data", m_data, tbl[2].exp);

        // random traffic against the frame-level model
        do_reset();
        q_frames.delete();
        cur_frame = '0;
        cur_len = 0;
        discarding = 1'b0;
        drv_cnt = 0;
        drv_target = 4;
        for (int c = 0; c < 3000; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 127));
            s_last  = (drv_cnt == drv_target - 1);
            m_ready = ($urandom_range(0, 2) != 0);
            model_cycle(1'b1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) model_cycle(1'b0);
        chk("rnd_final_m_valid", m_valid, 0);
        chk("rnd_final_queue", q_frames.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
